fifo_rd_drain: RTL and testbench

//  Downstream consumer of the FIFO read port: pops words while the FIFO reports
//  not-empty and absorbs the FIFO's 1-cycle read latency. Re-presents the words
//  on a valid/ready stream through a 2-entry skid buffer.

---
 rtl/fifo_rd_drain.sv | 190 +++++++++++++++++++
 tb/tb_fifo_rd_drain.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_drain.sv
// sync_fifo: small generic synchronous FIFO, DEPTH must be a power of two.
// Latency: a pushed word is visible on head_dat the cycle after the push edge.
// Backpressure: none internally; the caller must never push when full or pop when empty.
//
// Ports:
//   clk, rst           clock, async active-high reset (pointers and count only)
//   push, push_dat     write one word at the clock edge
//   pop                retire the head word at the clock edge
//   head_dat, count    oldest stored word, number of stored words
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_dat,
   input  logic                       pop,
   output logic [WIDTH-1:0]           head_dat,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    cnt;

   // Storage carries no reset: its contents are meaningless until written.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_dat;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   assign head_dat = mem[rd_ptr];
   assign count    = cnt;

endmodule

// fifo_rd_drain: pops a FIFO read port and re-presents the words on a valid/ready stream.
// Latency: fifo_rd_en_o in cycle t -> word on m_valid_o/m_data_o in cycle t+2.
// Backpressure: reads are credit-limited so buffered + in-flight words never exceed 2.
//
// Ports:
//   clk_i, rst_i                      read-side clock, async active-high reset
//   enable_i                          1 = fetch; 0 = stop fetching and drain what is pending
//   fifo_empty_i, fifo_error_i        FIFO status
//   fifo_rd_data_i, fifo_rd_en_o      FIFO read port (data valid the cycle after the enable)
//   m_valid_o, m_data_o, m_ready_i    output stream
//   rd_count_o                        delivered-word count, wraps
//   err_sticky_o, err_clr_i           sticky FIFO error flag and its clear
//   idle_o                            FSM resting in IDLE
module fifo_rd_drain #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             enable_i,
   input  logic             fifo_empty_i,
   input  logic             fifo_error_i,
   input  logic [WIDTH-1:0] fifo_rd_data_i,
   output logic             fifo_rd_en_o,
   output logic             m_valid_o,
   output logic [WIDTH-1:0] m_data_o,
   input  logic             m_ready_i,
   output logic [CNT_W-1:0] rd_count_o,
   output logic             err_sticky_o,
   input  logic             err_clr_i,
   output logic             idle_o
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   logic [1:0]       state_q;
   logic [1:0]       state_nxt;
   logic             inflight_q;
   logic [1:0]       occ;
   logic [WIDTH-1:0] head_dat;
   logic             pop;
   logic             push;
   logic             rd_en;
   logic [2:0]       credit_used;
   logic [2:0]       occ_after;
   logic [CNT_W-1:0] rd_count_q;
   logic             err_q;
   logic             idle_q;

   assign pop  = m_valid_o & m_ready_i;
   assign push = inflight_q;

   // Words already owed to the buffer after this cycle's pop; a new read is
   // only issued while that leaves room for the word it will return.
   assign credit_used = {1'b0, occ} + {2'b0, inflight_q} - {2'b0, pop};
   assign rd_en       = (state_q == S_RUN) & ~fifo_empty_i & (credit_used < 3'd2);
   assign occ_after   = {1'b0, occ} + {2'b0, push} - {2'b0, pop};

   sync_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (2)
   ) u_skid (
      .clk      (clk_i),
      .rst      (rst_i),
      .push     (push),
      .push_dat (fifo_rd_data_i),
      .pop      (pop),
      .head_dat (head_dat),
      .count    (occ)
   );

   // DRAIN exits on the occupancy that will hold after this edge, so the FSM
   // reaches IDLE in the cycle right after the final pop. No read is issued in
   // DRAIN, so nothing becomes in-flight on the way out.
   always_comb begin
      state_nxt = state_q;
      case (state_q)
         S_IDLE: begin
            if (enable_i) state_nxt = S_RUN;
         end
         S_RUN: begin
            if (!enable_i) state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            if (enable_i)               state_nxt = S_RUN;
            else if (occ_after == 3'd0) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         inflight_q <= 1'b0;
         rd_count_q <= '0;
         err_q      <= 1'b0;
         idle_q     <= 1'b0;
      end else begin
         state_q    <= state_nxt;
         inflight_q <= rd_en;
         if (pop) begin
            rd_count_q <= rd_count_q + CNT_W'(1);
         end
         // A new error outranks a simultaneous clear.
         if (fifo_error_i) begin
            err_q <= 1'b1;
         end else if (err_clr_i) begin
            err_q <= 1'b0;
         end
         // Registered so every output is 0 while reset is held; afterwards it
         // tracks state_q == S_IDLE exactly.
         idle_q <= (state_nxt == S_IDLE);
      end
   end

   assign fifo_rd_en_o = rd_en;
   assign m_valid_o    = (occ != 2'd0);
   // Gated so the undefined storage never shows on the port when nothing is valid.
   assign m_data_o     = m_valid_o ? head_dat : '0;
   assign rd_count_o   = rd_count_q;
   assign err_sticky_o = err_q;
   assign idle_o       = idle_q;

endmodule

// File: tb/tb_fifo_rd_drain.sv
module tb_fifo_rd_drain;

   localparam int WIDTH = 8;
   localparam int CNT_W = 16;
   localparam int LOGN  = 1024;

   logic             clk = 1'b0;
   logic             rst;
   logic             enable;
   logic             fifo_empty;
   logic             fifo_error;
   logic [WIDTH-1:0] fifo_rd_data;
   logic             fifo_rd_en;
   logic             m_valid;
   logic [WIDTH-1:0] m_data;
   logic             m_ready;
   logic [CNT_W-1:0] rd_count;
   logic             err_sticky;
   logic             err_clr;
   logic             idle;

   always #5 clk = ~clk;

   fifo_rd_drain #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .enable_i       (enable),
      .fifo_empty_i   (fifo_empty),
      .fifo_error_i   (fifo_error),
      .fifo_rd_data_i (fifo_rd_data),
      .fifo_rd_en_o   (fifo_rd_en),
      .m_valid_o      (m_valid),
      .m_data_o       (m_data),
      .m_ready_i      (m_ready),
      .rd_count_o     (rd_count),
      .err_sticky_o   (err_sticky),
      .err_clr_i      (err_clr),
      .idle_o         (idle)
   );

   // Model: words fetched but not yet delivered, each with the first cycle it may appear.
   typedef struct {
      logic [WIDTH-1:0] dat;
      int               avail;
   } ent_t;

   ent_t             mq[$];
   logic [WIDTH-1:0] src_q[$];
   logic             force_empty;
   logic [CNT_W-1:0] exp_count;
   logic             exp_err;
   int               cyc;
   int               checks;
   int               failures;

   logic             rden_log [LOGN];
   logic             vld_log  [LOGN];
   logic [WIDTH-1:0] dat_log  [LOGN];
   logic             idle_log [LOGN];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic drive_empty();
      fifo_empty = (src_q.size() == 0) || force_empty;
   endtask

   task automatic preload(input logic [WIDTH-1:0] base, input int n);
      for (int i = 0; i < n; i++) src_q.push_back(base + WIDTH'(i));
      drive_empty();
   endtask

   // Called at a negedge after inputs are set; returns at the next negedge.
   task automatic step();
      logic             exp_vld;
      logic             fetched;
      logic [WIDTH-1:0] fw;
      fetched = 1'b0;
      fw      = '0;
      #1;
      exp_vld = (mq.size() > 0) && (mq[0].avail <= cyc);
      chk("m_valid", m_valid, exp_vld);
      if (exp_vld) chk("m_data", m_data, mq[0].dat);
      chk("rd_count", rd_count, exp_count);
      chk("err_sticky", err_sticky, exp_err);
      chk("no_underflow", fifo_rd_en & fifo_empty, 1'b0);
      if (cyc < LOGN) begin
         rden_log[cyc] = fifo_rd_en;
         vld_log[cyc]  = m_valid;
         dat_log[cyc]  = m_data;
         idle_log[cyc] = idle;
      end
      if (!rst) begin
         if (exp_vld && m_ready) begin
            void'(mq.pop_front());
            exp_count++;
         end
         if (fifo_rd_en && src_q.size() > 0) begin
            fw      = src_q.pop_front();
            fetched = 1'b1;
            mq.push_back('{dat: fw, avail: cyc + 2});
         end
         if (fifo_error)   exp_err = 1'b1;
         else if (err_clr) exp_err = 1'b0;
      end
      chk("credit_le_2", (mq.size() <= 2), 1'b1);
      @(posedge clk);
      #1;
      if (fetched) fifo_rd_data = fw;
      drive_empty();
      cyc++;
      @(negedge clk);
   endtask

   task automatic run_until_drained(input string name, input int budget);
      int n;
      n = 0;
      while ((mq.size() > 0 || src_q.size() > 0) && n < budget) begin
         step();
         n++;
      end
      chk(name, (mq.size() == 0 && src_q.size() == 0), 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int t0;
      checks = 0; failures = 0; cyc = 0;
      rst = 1'b1; enable = 1'b0; fifo_error = 1'b0; err_clr = 1'b0;
      m_ready = 1'b0; force_empty = 1'b0; fifo_rd_data = '0;
      exp_count = '0; exp_err = 1'b0;
      drive_empty();

      // Reset state
      #1;
      chk("rst_rd_en", fifo_rd_en, 1'b0);
      chk("rst_valid", m_valid, 1'b0);
      chk("rst_data", m_data, 8'h00);
      chk("rst_count", rd_count, 16'h0000);
      chk("rst_err", err_sticky, 1'b0);
      chk("rst_idle", idle, 1'b0);
      @(negedge clk);
      step();
      step();
      rst = 1'b0;
      step();
      chk("idle_after_rst", idle, 1'b1);

      // 1: four preloaded words, ready held high
      enable = 1'b1; m_ready = 1'b1;
      step();
      preload(8'hA0, 4);
      t0 = cyc;
      repeat (8) step();
      for (int i = 0; i < 4; i++) chk("t1_rd_en_hi", rden_log[t0 + i], 1'b1);
      chk("t1_rd_en_lo", rden_log[t0 + 4], 1'b0);
      chk("t1_valid_c1", vld_log[t0 + 1], 1'b0);
      for (int i = 2; i < 6; i++) begin
         chk("t1_valid", vld_log[t0 + i], 1'b1);
         chk("t1_data", dat_log[t0 + i], 8'hA0 + WIDTH'(i - 2));
      end
      chk("t1_valid_c6", vld_log[t0 + 6], 1'b0);
      chk("t1_count", rd_count, 16'd4);

      // 2: eight words, ready low in cycles 3-7
      preload(8'hB0, 8);
      t0 = cyc;
      for (int i = 0; i < 20; i++) begin
         m_ready = !(i >= 3 && i <= 7);
         step();
      end
      m_ready = 1'b1;
      for (int i = 0; i < 3; i++) chk("t2_rd_en_hi", rden_log[t0 + i], 1'b1);
      for (int i = 3; i < 8; i++) begin
         chk("t2_rd_en_stall", rden_log[t0 + i], 1'b0);
         chk("t2_hold_valid", vld_log[t0 + i], 1'b1);
         chk("t2_hold_data", dat_log[t0 + i], 8'hB1);
      end
      chk("t2_rd_en_resume", rden_log[t0 + 8], 1'b1);
      run_until_drained("t2_all_delivered", 10);
      chk("t2_count", rd_count, 16'd12);

      // 3: FIFO empty for 20 cycles while enabled
      force_empty = 1'b1;
      drive_empty();
      t0 = cyc;
      repeat (20) step();
      for (int i = 0; i < 20; i++) begin
         chk("t3_rd_en", rden_log[t0 + i], 1'b0);
         chk("t3_valid", vld_log[t0 + i], 1'b0);
      end
      force_empty = 1'b0;
      drive_empty();

      // 4: drop enable with one buffered and one in-flight word
      preload(8'hC0, 10);
      t0 = cyc;
      repeat (3) step();
      enable = 1'b0; m_ready = 1'b0;
      step();
      m_ready = 1'b1;
      repeat (9) step();
      for (int i = 0; i < 3; i++) chk("t4_rd_en_hi", rden_log[t0 + i], 1'b1);
      for (int i = 3; i < 13; i++) chk("t4_no_rd_en", rden_log[t0 + i], 1'b0);
      chk("t4_valid_c4", vld_log[t0 + 4], 1'b1);
      chk("t4_data_c4", dat_log[t0 + 4], 8'hC1);
      chk("t4_valid_c5", vld_log[t0 + 5], 1'b1);
      chk("t4_data_c5", dat_log[t0 + 5], 8'hC2);
      chk("t4_valid_c6", vld_log[t0 + 6], 1'b0);
      chk("t4_idle_c5", idle_log[t0 + 5], 1'b0);
      chk("t4_idle_c6", idle_log[t0 + 6], 1'b1);
      chk("t4_count", rd_count, 16'd15);

      // 5: sticky error, set wins over clear
      fifo_error = 1'b1; err_clr = 1'b0;
      step();
      chk("t5_err_set", err_sticky, 1'b1);
      fifo_error = 1'b1; err_clr = 1'b1;
      step();
      chk("t5_err_both", err_sticky, 1'b1);
      fifo_error = 1'b0; err_clr = 1'b1;
      step();
      chk("t5_err_clr", err_sticky, 1'b0);
      err_clr = 1'b0;

      // 6: async reset with two words buffered
      enable = 1'b1; m_ready = 1'b0;
      step();
      fifo_error = 1'b1;
      step();
      fifo_error = 1'b0;
      repeat (2) step();
      #1;
      chk("t6_pre_valid", m_valid, 1'b1);
      chk("t6_pre_err", err_sticky, 1'b1);
      rst = 1'b1;
      #1;
      chk("t6_rst_rd_en", fifo_rd_en, 1'b0);
      chk("t6_rst_valid", m_valid, 1'b0);
      chk("t6_rst_data", m_data, 8'h00);
      chk("t6_rst_count", rd_count, 16'h0000);
      chk("t6_rst_err", err_sticky, 1'b0);
      chk("t6_rst_idle", idle, 1'b0);
      mq.delete();
      exp_count = '0;
      exp_err   = 1'b0;
      @(negedge clk);
      step();
      step();
      rst = 1'b0;
      m_ready = 1'b1;
      step();
      chk("t6_count_after", rd_count, 16'h0000);
      t0 = cyc;
      run_until_drained("t6_restart_drained", 30);
      chk("t6_first_word", dat_log[t0 + 2], 8'hC5);
      chk("t6_count_end", rd_count, 16'd5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
